// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes and decides
// load-use stalls and registered EX forwarding selects.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic              id_wen_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_load_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [STAGES-1:0]             e_vld;
  logic [STAGES-1:0]             e_wen;
  logic [STAGES-1:0]             e_ld;
  logic [STAGES-1:0][REG_AW-1:0] e_rd;

  logic             st_a, st_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             issue;
  logic             wen_in;
  logic [REG_AW-1:0] rd_in;

  // Youngest matching producer decides: {stall, select}
  function automatic logic [SEL_W:0] lookup(
    input logic [REG_AW-1:0]             src,
    input logic                          used,
    input logic [STAGES-1:0]             vld,
    input logic [STAGES-1:0]             wen,
    input logic [STAGES-1:0]             ld,
    input logic [STAGES-1:0][REG_AW-1:0] rd
  );
    logic hit;
    logic hld;
    int   hk;
    hit = 1'b0;
    hld = 1'b0;
    hk  = 0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (vld[k] && wen[k] && rd[k] == src) begin
        hit = 1'b1;
        hld = ld[k];
        hk  = k;
      end
    end
    lookup = '0;
    if (used && hit && hk != STAGES - 1) begin
      if (hld && (hk + 1) < LOAD_STAGE)
        lookup[SEL_W] = 1'b1;
      else
        lookup[SEL_W-1:0] = SEL_W'(hk + 1);
    end
  endfunction

  // Per-source readiness and the resulting stall / write enables
  always_comb begin
    {st_a, sel_a} = lookup(id_rs_i, id_rs_used_i,
                           e_vld, e_wen, e_ld, e_rd);
    {st_b, sel_b} = lookup(id_rt_i, id_rt_used_i,
                           e_vld, e_wen, e_ld, e_rd);
    stall_o      = id_valid_i & ~flush_i & (st_a | st_b);
    issue        = id_valid_i & ~flush_i & ~stall_o;
    pc_write_o   = ~stall_o & ~hold_i;
    ifid_write_o = ~stall_o & ~hold_i;
    wen_in       = issue & id_wen_i & (id_rd_i != '0);
    rd_in        = issue ? id_rd_i : '0;
  end

  // Shift scoreboard, register selects, count stall cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_vld       <= '0;
      e_wen       <= '0;
      e_ld        <= '0;
      e_rd        <= '0;
      fwd_a_o     <= '0;
      fwd_b_o     <= '0;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      e_vld   <= {e_vld[STAGES-2:0], issue};
      e_wen   <= {e_wen[STAGES-2:0], wen_in};
      e_ld    <= {e_ld[STAGES-2:0], issue & id_load_i};
      e_rd    <= {e_rd[STAGES-2:0], rd_in};
      fwd_a_o <= issue ? sel_a : '0;
      fwd_b_o <= issue ? sel_b : '0;
      if (stall_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random
// traffic against an age-based in-flight write model.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int ST = 3;
  localparam int LS = 2;
  localparam int CW = 16;
  localparam int SW = $clog2(ST + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          id_valid_i;
  logic [AW-1:0] id_rs_i;
  logic [AW-1:0] id_rt_i;
  logic          id_rs_used_i;
  logic          id_rt_used_i;
  logic          id_wen_i;
  logic [AW-1:0] id_rd_i;
  logic          id_load_i;
  logic          flush_i;
  logic          hold_i;
  logic          stall_o, pc_write_o, ifid_write_o;
  logic [SW-1:0] fwd_a_o, fwd_b_o;
  logic [CW-1:0] stall_cnt_o;

  logic          stall4, pcw4, ifw4;
  logic [2:0]    fa4, fb4;
  logic [CW-1:0] cnt4;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_used_i(id_rs_used_i),
    .id_rt_used_i(id_rt_used_i),
    .id_wen_i(id_wen_i), .id_rd_i(id_rd_i),
    .id_load_i(id_load_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o)
  );

  hazard_scoreboard #(.STAGES(4), .LOAD_STAGE(3)) u4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rs_used_i(id_rs_used_i),
    .id_rt_used_i(id_rt_used_i),
    .id_wen_i(id_wen_i), .id_rd_i(id_rd_i),
    .id_load_i(id_load_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall4), .pc_write_o(pcw4),
    .ifid_write_o(ifw4),
    .fwd_a_o(fa4), .fwd_b_o(fb4),
    .stall_cnt_o(cnt4)
  );

  // Model: in-flight writers with age = cycles since issue
  typedef struct {
    int rd;
    bit ld;
    int age;
  } rec_t;

  rec_t q[$];
  int   m_fa, m_fb, m_cnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic void look(input int src, input bit used,
                               output bit st, output int sel);
    int best;
    bit bl;
    best = 0;
    bl   = 0;
    st   = 0;
    sel  = 0;
    foreach (q[i])
      if (q[i].rd == src && (best == 0 || q[i].age < best)) begin
        best = q[i].age;
        bl   = q[i].ld;
      end
    if (!used || best == 0 || best == ST) return;
    if (bl && best < LS) st = 1;
    else sel = best;
  endfunction

  task automatic model_clear();
    q.delete();
    m_fa  = 0;
    m_fb  = 0;
    m_cnt = 0;
  endtask

  task automatic set_in(input bit v, input int rs, input int rt,
                        input bit ru, input bit tu, input bit w,
                        input int rd, input bit ld,
                        input bit fl, input bit hd);
    id_valid_i   = v;
    id_rs_i      = AW'(rs);
    id_rt_i      = AW'(rt);
    id_rs_used_i = ru;
    id_rt_used_i = tu;
    id_wen_i     = w;
    id_rd_i      = AW'(rd);
    id_load_i    = ld;
    flush_i      = fl;
    hold_i       = hd;
  endtask

  // One clock: drive, check against model, advance model
  task automatic step(input bit v, input int rs, input int rt,
                      input bit ru, input bit tu, input bit w,
                      input int rd, input bit ld,
                      input bit fl, input bit hd);
    bit sa, sb, stl, iss;
    int sela, selb;
    set_in(v, rs, rt, ru, tu, w, rd, ld, fl, hd);
    #1;
    look(rs, ru, sa, sela);
    look(rt, tu, sb, selb);
    stl = v && !fl && (sa || sb);
    iss = v && !fl && !stl;
    chk("stall", 32'(stall_o), 32'(stl));
    chk("pc_write", 32'(pc_write_o), 32'(!stl && !hd));
    chk("ifid_write", 32'(ifid_write_o), 32'(!stl && !hd));
    chk("fwd_a", 32'(fwd_a_o), m_fa);
    chk("fwd_b", 32'(fwd_b_o), m_fb);
    chk("stall_cnt", 32'(stall_cnt_o), m_cnt);
    @(posedge clk_i);
    if (rst_i) begin
      model_clear();
    end else if (!hd) begin
      foreach (q[i]) q[i].age = q[i].age + 1;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].age > ST) q.delete(i);
      if (iss && w && rd != 0) q.push_back('{rd, ld, 1});
      m_fa = iss ? sela : 0;
      m_fb = iss ? selb : 0;
      if (stl && m_cnt < 65535) m_cnt++;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_clear();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_pcw", 32'(pc_write_o), 1);
    chk("rst_cnt", 32'(stall_cnt_o), 0);
    chk("rst_fwd", 32'({fwd_a_o, fwd_b_o}), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // lw r2 ; add r3,r2,r1
    step(1, 1, 0, 1, 0, 1, 2, 1, 0, 0);
    step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    chk("lu_cnt", 32'(stall_cnt_o), 1);
    step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    chk("lu_fwd_a", 32'(fwd_a_o), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add r2 ; add r4,r2,r2 with 0/1/2 gaps
    for (int g = 0; g < 3; g++) begin
      step(1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
      for (int k = 0; k < g; k++)
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 2, 2, 1, 1, 1, 4, 0, 0, 0);
      chk("gap_fwd_a", 32'(fwd_a_o), (g == 2) ? 0 : g + 1);
      chk("gap_fwd_b", 32'(fwd_b_o), (g == 2) ? 0 : g + 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // youngest wins; r0 never forwards
    step(1, 1, 1, 1, 1, 1, 5, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 5, 0, 0, 0);
    step(1, 5, 0, 1, 1, 1, 6, 0, 0, 0);
    chk("young_fwd_a", 32'(fwd_a_o), 1);
    step(1, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 7, 0, 0, 0);
    chk("r0_fwd", 32'({fwd_a_o, fwd_b_o}), 0);

    // hold for 3 cycles over a load-use stall
    step(1, 1, 0, 1, 0, 1, 2, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      step(1, 2, 1, 1, 1, 1, 3, 0, 0, 1);
    chk("hold_cnt", 32'(stall_cnt_o), m_cnt);
    step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);

    // flush a dependent instruction
    step(1, 1, 0, 1, 0, 1, 2, 1, 0, 0);
    step(1, 2, 2, 1, 1, 1, 3, 0, 1, 0);
    chk("flush_fwd", 32'({fwd_a_o, fwd_b_o}), 0);

    // reset asserted during a load-use stall
    step(1, 1, 0, 1, 0, 1, 2, 1, 0, 0);
    set_in(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    #1;
    chk("pre_rst_stall", 32'(stall_o), 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 0);
    chk("mid_rst_cnt", 32'(stall_cnt_o), 0);
    @(negedge clk_i);
    model_clear();
    step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    rst_i = 1'b0;

    // deeper pipe: STAGES=4, LOAD_STAGE=3 gives two stalls
    do_reset();
    step(1, 1, 0, 1, 0, 1, 2, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_in(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
      #1;
      chk("deep_stall", 32'(stall4), (k < 2) ? 1 : 0);
      step(1, 2, 1, 1, 1, 1, 3, 0, 0, 0);
    end
    chk("deep_fwd_a", 32'(fa4), 3);
    chk("deep_cnt", 32'(cnt4), 2);

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 8,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3),
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
